// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared types and constants for the fetch front end
package ifetch_queue_pkg;

  localparam int                XLEN             = 32;
  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_1000;
  localparam logic [XLEN-1:0]   PC_INCR          = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

  // Fetch addresses are word aligned; the low two bits of any target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// rtl/ifetch_queue_fetch_fifo.sv - DEPTH-entry fetch FIFO with flush and registered head
module fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fq_entry_t        push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [PTR_W:0]   count_o,
  output logic             head_valid_o,
  output fq_entry_t        head_o
);

  localparam int CNT_W = PTR_W + 1;

  fq_entry_t              mem_q [DEPTH];
  fq_entry_t              mem_d [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_next;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;
  fq_entry_t              head_q, head_d;
  logic                   do_pop;

  assign do_pop  = pop_i & valid_q;
  assign rd_next = rd_ptr_q + 1'b1;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    head_d   = head_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      head_d   = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_next;
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
      valid_d = (count_d != '0);
      // The head register always mirrors the oldest live entry, so it is
      // refilled either from the next stored slot or straight from the push.
      if (do_pop) begin
        if (count_q > CNT_W'(1)) begin
          head_d = mem_q[rd_next];
        end else if (push_i) begin
          head_d = push_data_i;
        end
      end else if ((count_q == '0) && push_i) begin
        head_d = push_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - PC generator, in-flight tracking and credit control in front of the I-cache
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] ic_addr_o,
  output logic        ic_freeze_o,
  input  logic [31:0] ic_instr_i,
  input  logic        ic_stall_i,
  output logic        dq_valid_o,
  input  logic        dq_ready_i,
  output logic [31:0] dq_instr_o,
  output logic [31:0] dq_pc_o
);

  localparam int CRD_W = PTR_W + 2;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             inflight_v_q, inflight_v_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;

  logic [31:0]      redirect_target;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_valid;
  fq_entry_t        fifo_head;
  fq_entry_t        push_data;
  logic             pop;
  logic             resp_fire;
  logic             push;
  logic             credit;
  logic             issue;
  logic [CRD_W-1:0] occupancy;

  assign redirect_target = align_pc(redirect_pc_i);
  assign pop             = fifo_valid & dq_ready_i;
  assign resp_fire       = inflight_v_q & ~ic_stall_i;

  // Occupancy counts the outstanding request as already holding a slot, so
  // a new fetch is only issued when its response is guaranteed a place.
  assign occupancy   = CRD_W'(fifo_count) + CRD_W'(inflight_v_q) - CRD_W'(pop);
  assign credit      = occupancy < CRD_W'(DEPTH);
  assign ic_freeze_o = ~credit & ~redirect_i;
  assign issue       = ~ic_stall_i & (credit | redirect_i);
  assign push        = resp_fire & ~redirect_i;
  assign ic_addr_o   = redirect_i ? redirect_target : fetch_pc_q;

  assign push_data.instr = ic_instr_i;
  assign push_data.pc    = inflight_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_v_d  = inflight_v_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect_i) begin
      if (!ic_stall_i) begin
        inflight_v_d  = 1'b1;
        inflight_pc_d = redirect_target;
        fetch_pc_d    = redirect_target + PC_INCR;
      end else begin
        // The pending miss still completes, but with nothing marked in flight
        // its word is dropped and the target goes out in that same cycle.
        inflight_v_d = 1'b0;
        fetch_pc_d   = redirect_target;
      end
    end else if (issue) begin
      inflight_v_d  = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + PC_INCR;
    end else if (resp_fire) begin
      inflight_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (pop & ~redirect_i),
    .flush_i      (redirect_i),
    .count_o      (fifo_count),
    .head_valid_o (fifo_valid),
    .head_o       (fifo_head)
  );

  assign dq_valid_o = fifo_valid;
  assign dq_instr_o = fifo_head.instr;
  assign dq_pc_o    = fifo_head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed and random checks of ifetch_queue against a queue-based model
module tb_ifetch_queue;

  localparam logic [31:0] K    = 32'hA5A5_0000;
  localparam logic [31:0] RPC  = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] ic_addr_o;
  logic        ic_freeze_o;
  logic [31:0] ic_instr_i;
  logic        ic_stall_i;
  logic        dq_valid_o;
  logic        dq_ready_i;
  logic [31:0] dq_instr_o;
  logic [31:0] dq_pc_o;

  ifetch_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ic_addr_o     (ic_addr_o),
    .ic_freeze_o   (ic_freeze_o),
    .ic_instr_i    (ic_instr_i),
    .ic_stall_i    (ic_stall_i),
    .dq_valid_o    (dq_valid_o),
    .dq_ready_i    (dq_ready_i),
    .dq_instr_o    (dq_instr_o),
    .dq_pc_o       (dq_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] m_fetch;
  logic        m_inf_v;
  logic [31:0] m_inf_pc;
  logic [31:0] m_lat;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch  = RPC;
    m_inf_v  = 1'b0;
    m_inf_pc = '0;
    mq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    ic_stall_i    = 1'b0;
    dq_ready_i    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},   ic_addr_o, RPC);
    chk({tag, "_freeze"}, 32'(ic_freeze_o), 32'd0);
    chk({tag, "_valid"},  32'(dq_valid_o), 32'd0);
    chk({tag, "_pc"},     dq_pc_o, 32'd0);
    chk({tag, "_instr"},  dq_instr_o, 32'd0);
  endtask

  // One clock: drive inputs at the falling edge, compare against the model,
  // then advance the model across the rising edge.
  task automatic cyc(input logic r, input logic [31:0] rpc, input logic s, input logic rd);
    int          cnt;
    int          occ;
    logic        valid;
    logic        pop;
    logic        credit;
    logic        freeze;
    logic        issue;
    logic [31:0] addr;
    logic [31:0] tgt;
    redirect_i    = r;
    redirect_pc_i = rpc;
    ic_stall_i    = s;
    dq_ready_i    = rd;
    #1;
    cnt    = mq.size();
    valid  = (cnt > 0);
    pop    = valid && rd;
    credit = (cnt + int'(m_inf_v) - int'(pop)) < 4;
    freeze = !credit && !r;
    tgt    = {rpc[31:2], 2'b00};
    addr   = r ? tgt : m_fetch;
    issue  = !s && (credit || r);
    chk("ic_addr",   ic_addr_o, addr);
    chk("ic_freeze", 32'(ic_freeze_o), 32'(freeze));
    chk("dq_valid",  32'(dq_valid_o), 32'(valid));
    if (valid) begin
      chk("dq_pc",    dq_pc_o, mq[0].pc);
      chk("dq_instr", dq_instr_o, mq[0].instr);
    end
    occ = int'(dut.fifo_count) + int'(dut.inflight_v_q);
    chk("occupancy_le_depth", 32'(occ <= 4), 32'd1);
    @(posedge clk);
    if (!s && !freeze) m_lat = addr;
    if (r) begin
      mq.delete();
      if (!s) begin
        m_inf_v  = 1'b1;
        m_inf_pc = tgt;
        m_fetch  = tgt + 32'd4;
      end else begin
        m_inf_v = 1'b0;
        m_fetch = tgt;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_inf_v && !s) mq.push_back('{pc: m_inf_pc, instr: m_inf_pc ^ K});
      if (issue) begin
        m_inf_pc = m_fetch;
        m_inf_v  = 1'b1;
        m_fetch  = m_fetch + 32'd4;
      end else if (m_inf_v && !s) begin
        m_inf_v = 1'b0;
      end
    end
    @(negedge clk);
    ic_instr_i = m_lat ^ K;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    ic_stall_i    = 1'b0;
    dq_ready_i    = 1'b0;
    m_lat         = '0;
    ic_instr_i    = K;
    model_reset();
    @(negedge clk);

    // Streaming after reset release.
    do_reset();
    chk_reset_outputs("reset");
    cyc(0, 0, 0, 1);
    chk("stream_addr1", ic_addr_o, 32'h1004);
    chk("stream_valid1", 32'(dq_valid_o), 32'd0);
    cyc(0, 0, 0, 1);
    chk("stream_addr2", ic_addr_o, 32'h1008);
    chk("stream_valid2", 32'(dq_valid_o), 32'd1);
    chk("stream_pc2", dq_pc_o, 32'h1000);
    chk("stream_instr2", dq_instr_o, 32'h1000 ^ K);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // Decode not ready: the queue fills and fetch freezes.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    chk("full_freeze", 32'(ic_freeze_o), 32'd1);
    chk("full_addr", ic_addr_o, 32'h1010);
    chk("full_head", dq_pc_o, 32'h1000);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

    // Ten-cycle miss after 0x1004 issues.
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1);
    chk("stall_hold_addr", ic_addr_o, 32'h1008);
    chk("stall_no_push", 32'(dq_valid_o), 32'd0);
    cyc(0, 0, 0, 1);
    chk("stall_resume_valid", 32'(dq_valid_o), 32'd1);
    chk("stall_resume_pc", dq_pc_o, 32'h1004);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    // Redirect with three entries queued and one in flight.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(1, 32'h2002, 0, 0);
    chk("redir_flush_valid", 32'(dq_valid_o), 32'd0);
    cyc(0, 0, 0, 1);
    chk("redir_first_pc", dq_pc_o, 32'h2000);
    chk("redir_first_valid", 32'(dq_valid_o), 32'd1);
    cyc(0, 0, 0, 1);
    chk("redir_second_pc", dq_pc_o, 32'h2004);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    // Redirect while the cache is stalled: the stale word must be dropped.
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(1, 32'h3000, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    chk("stale_hold_addr", ic_addr_o, 32'h3000);
    cyc(0, 0, 0, 1);
    chk("stale_dropped", 32'(dq_valid_o), 32'd0);
    cyc(0, 0, 0, 1);
    chk("stale_first_pc", dq_pc_o, 32'h3000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    // Full queue draining while refilling at one word per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1);
      chk("full_stream_valid", 32'(dq_valid_o), 32'd1);
      chk("full_stream_pc", dq_pc_o, 32'(32'h1000 + 4 * (i + 1)));
      chk("full_stream_freeze", 32'(ic_freeze_o), 32'd0);
    end

    // Address wrap, then asynchronous reset in the middle of a miss.
    do_reset();
    cyc(1, 32'hFFFF_FFF8, 0, 1);
    redirect_i = 1'b0;
    #1;
    chk("wrap_addr_fffc", ic_addr_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("wrap_addr_zero", ic_addr_o, 32'h0000_0000);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    do_reset();
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
